// File: rtl/vp_pkg.sv
// Types and constants shared by the video-processing stages.
package vp_pkg;
  localparam int PIX_W         = 8;
  localparam int GRAD_W        = 12;
  localparam int SOBEL_LATENCY = 4;

  typedef struct packed {
    logic vsync;
    logic hsync;
    logic de;
  } pixel_sync_t;

  function automatic logic [PIX_W-1:0] sat_grad(input logic [GRAD_W-1:0] mag);
    if (mag > GRAD_W'(255)) begin
      sat_grad = {PIX_W{1'b1}};
    end else begin
      sat_grad = mag[PIX_W-1:0];
    end
  endfunction
endpackage

// File: rtl/sobel_line_buf.sv
// Two-line luma buffer: simple dual-port RAM, registered read, old data on a same-address write.
module sobel_line_buf #(
  parameter int DEPTH  = 640,
  parameter int ADDR_W = 10,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdata;

  // Write port; contents are never cleared, row gating hides stale data.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Registered read port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdata <= '0;
    end else begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;
endmodule

// File: rtl/ycbcr_sobel_edge.sv
// 3x3 Sobel on the Y channel: two-line RAM buffer, 4-stage pipeline, saturated
// gradient magnitude and thresholded edge bit, with sync delayed to match.
module ycbcr_sobel_edge
  import vp_pkg::*;
#(
  parameter int H_ACTIVE = 640,
  parameter int ADDR_W   = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pre_frame_vsync,
  input  logic             pre_frame_hsync,
  input  logic             pre_frame_de,
  input  logic [PIX_W-1:0] img_y,
  input  logic [PIX_W-1:0] threshold,
  output logic             post_frame_vsync,
  output logic             post_frame_hsync,
  output logic             post_frame_de,
  output logic [PIX_W-1:0] post_img_grad,
  output logic             post_img_bit
);
  localparam logic [ADDR_W-1:0] COL_MAX = ADDR_W'(H_ACTIVE - 1);

  logic [ADDR_W-1:0]  r_col;
  logic               r_col_ovf;
  logic [1:0]         r_row;
  logic               r_de_d;
  logic               r_vs_d;
  logic               w_wr_en;
  logic               w_pix_valid;
  pixel_sync_t        r_sync_sr [SOBEL_LATENCY];
  logic [PIX_W-1:0]   r1_y;
  logic [ADDR_W-1:0]  r1_col;
  logic               r1_wr;
  logic               r1_valid;
  logic               r1_de;
  logic [2*PIX_W-1:0] w_rdata;
  logic [PIX_W-1:0]   r_win [3][3];
  logic               r2_valid;
  logic [10:0]        w_gx_pos, w_gx_neg, w_gy_pos, w_gy_neg;
  logic signed [10:0] r3_gx, r3_gy;
  logic               r3_valid;
  logic [10:0]        w_ax, w_ay;
  logic [GRAD_W-1:0]  w_mag;
  logic [PIX_W-1:0]   w_grad;
  logic [PIX_W-1:0]   r_grad;
  logic               r_bit;

  // Pixels past the last buffer column are neither stored nor scored.
  assign w_wr_en     = pre_frame_de && !r_col_ovf;
  assign w_pix_valid = w_wr_en && (r_row == 2'd2) && (r_col >= ADDR_W'(2));

  // Column/row counters and edge detectors.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_col     <= '0;
      r_col_ovf <= 1'b0;
      r_row     <= 2'd0;
      r_de_d    <= 1'b0;
      r_vs_d    <= 1'b0;
    end else begin
      r_de_d <= pre_frame_de;
      r_vs_d <= pre_frame_vsync;
      if (!pre_frame_de) begin
        r_col     <= '0;
        r_col_ovf <= 1'b0;
      end else if (r_col == COL_MAX) begin
        r_col_ovf <= 1'b1;
      end else begin
        r_col <= r_col + ADDR_W'(1);
      end
      if (pre_frame_vsync && !r_vs_d) begin
        r_row <= 2'd0;
      end else if (r_de_d && !pre_frame_de && (r_row != 2'd2)) begin
        r_row <= r_row + 2'd1;
      end
    end
  end

  // Sync delay line matching the data pipeline depth.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SOBEL_LATENCY; i++) r_sync_sr[i] <= '0;
    end else begin
      r_sync_sr[0] <= {pre_frame_vsync, pre_frame_hsync, pre_frame_de};
      for (int i = 1; i < SOBEL_LATENCY; i++) r_sync_sr[i] <= r_sync_sr[i-1];
    end
  end

  // The buffer write lands one clock after its read, using the registered older row.
  sobel_line_buf #(
    .DEPTH  (H_ACTIVE),
    .ADDR_W (ADDR_W),
    .DATA_W (2*PIX_W)
  ) u_line_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_we    (r1_wr),
    .i_waddr (r1_col),
    .i_wdata ({r1_y, w_rdata[2*PIX_W-1:PIX_W]}),
    .i_raddr (r_col),
    .o_rdata (w_rdata)
  );

  // Stage 1 (alongside the RAM read) and stage 2 window shift.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r1_y     <= '0;
      r1_col   <= '0;
      r1_wr    <= 1'b0;
      r1_valid <= 1'b0;
      r1_de    <= 1'b0;
      r2_valid <= 1'b0;
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++) r_win[r][c] <= '0;
    end else begin
      r1_y     <= img_y;
      r1_col   <= r_col;
      r1_wr    <= w_wr_en;
      r1_valid <= w_pix_valid;
      r1_de    <= pre_frame_de;
      r2_valid <= r1_valid;
      if (!r1_de) begin
        for (int r = 0; r < 3; r++)
          for (int c = 0; c < 3; c++) r_win[r][c] <= '0;
      end else begin
        for (int r = 0; r < 3; r++)
          for (int c = 0; c < 2; c++) r_win[r][c] <= r_win[r][c+1];
        r_win[0][2] <= w_rdata[PIX_W-1:0];
        r_win[1][2] <= w_rdata[2*PIX_W-1:PIX_W];
        r_win[2][2] <= r1_y;
      end
    end
  end

  // Weighted column/row sums; each fits in 11 bits unsigned (max 1020).
  always_comb begin
    w_gx_pos = {3'b000, r_win[0][2]} + {2'b00, r_win[1][2], 1'b0} + {3'b000, r_win[2][2]};
    w_gx_neg = {3'b000, r_win[0][0]} + {2'b00, r_win[1][0], 1'b0} + {3'b000, r_win[2][0]};
    w_gy_pos = {3'b000, r_win[2][0]} + {2'b00, r_win[2][1], 1'b0} + {3'b000, r_win[2][2]};
    w_gy_neg = {3'b000, r_win[0][0]} + {2'b00, r_win[0][1], 1'b0} + {3'b000, r_win[0][2]};
  end

  // Stage 3: signed gradients.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r3_gx    <= '0;
      r3_gy    <= '0;
      r3_valid <= 1'b0;
    end else begin
      r3_gx    <= w_gx_pos - w_gx_neg;
      r3_gy    <= w_gy_pos - w_gy_neg;
      r3_valid <= r2_valid;
    end
  end

  assign w_ax   = r3_gx[10] ? (11'd0 - r3_gx) : r3_gx;
  assign w_ay   = r3_gy[10] ? (11'd0 - r3_gy) : r3_gy;
  assign w_mag  = {1'b0, w_ax} + {1'b0, w_ay};
  assign w_grad = sat_grad(w_mag);

  // Stage 4: magnitude and edge decision, zero outside valid pixels.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_grad <= '0;
      r_bit  <= 1'b0;
    end else begin
      r_grad <= r3_valid ? w_grad : '0;
      r_bit  <= r3_valid && (w_grad > threshold);
    end
  end

  assign post_frame_vsync = r_sync_sr[SOBEL_LATENCY-1].vsync;
  assign post_frame_hsync = r_sync_sr[SOBEL_LATENCY-1].hsync;
  assign post_frame_de    = r_sync_sr[SOBEL_LATENCY-1].de;
  assign post_img_grad    = r_grad;
  assign post_img_bit     = r_bit;
endmodule
